cdc_multi_edge_detector: RTL and testbench



---
 rtl/cdc_multi_edge_detector.sv | 155 +++++++++++++++
 tb/tb_cdc_multi_edge_detector.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/cdc_multi_edge_detector.sv
// Multi-channel slow-to-fast CDC edge detector with warm-up gating, edge-mode qualify and saturating counters.
// Optional macro CDC_GLITCH_FILTER_EN adds a two-sample stability filter ahead of the level register.
module cdc_multi_edge_detector #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                          fast_clk,
  input  logic                          rst,
  input  logic [CHANNELS-1:0]           slow_data,
  input  logic [1:0]                    edge_mode,
  input  logic                          count_clr,
  output logic                          ready,
  output logic [CHANNELS-1:0]           data_rise,
  output logic [CHANNELS-1:0]           data_fall,
  output logic [CHANNELS-1:0]           data_edge,
  output logic                          any_edge,
  output logic [CHANNELS*CNT_WIDTH-1:0] edge_count
);

`ifdef CDC_GLITCH_FILTER_EN
  localparam int WARM_CYCLES = SYNC_STAGES + 2;
`else
  localparam int WARM_CYCLES = SYNC_STAGES + 1;
`endif
  localparam int WARM_W = $clog2(WARM_CYCLES + 1);

  logic [SYNC_STAGES-1:0][CHANNELS-1:0] r_sync;
  logic [CHANNELS-1:0]                  r_lvl;
  logic [CHANNELS-1:0]                  w_sync_last;
  logic [CHANNELS-1:0]                  w_lvl_next;
  logic [CHANNELS-1:0]                  w_rise_raw;
  logic [CHANNELS-1:0]                  w_fall_raw;
  logic [CHANNELS-1:0]                  w_edge_sel;
  logic [CHANNELS-1:0]                  w_en_mask;
  logic [WARM_W-1:0]                    r_warm_cnt;
  logic                                 r_ready;
  logic [CHANNELS-1:0]                  r_rise;
  logic [CHANNELS-1:0]                  r_fall;
  logic [CHANNELS-1:0]                  r_edge;
  logic                                 r_any;

  assign w_sync_last = r_sync[SYNC_STAGES-1];

  // Synchroniser chain: stage 0 is the only flop that sees the asynchronous input.
  always_ff @(posedge fast_clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= slow_data;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

`ifdef CDC_GLITCH_FILTER_EN
  logic [CHANNELS-1:0] r_sync_d;
  logic [CHANNELS-1:0] w_stable;

  // Previous synchronised sample for the stability filter.
  always_ff @(posedge fast_clk or posedge rst) begin
    if (rst) begin
      r_sync_d <= '0;
    end else begin
      r_sync_d <= w_sync_last;
    end
  end

  // The level only moves once two consecutive samples agree.
  assign w_stable   = ~(w_sync_last ^ r_sync_d);
  assign w_lvl_next = (w_stable & w_sync_last) | (~w_stable & r_lvl);
`else
  assign w_lvl_next = w_sync_last;
`endif

  assign w_rise_raw = w_lvl_next & ~r_lvl;
  assign w_fall_raw = ~w_lvl_next & r_lvl;
  assign w_en_mask  = {CHANNELS{r_ready}};

  // Level register tracks the synchronised input even during warm-up.
  always_ff @(posedge fast_clk or posedge rst) begin
    if (rst) begin
      r_lvl <= '0;
    end else begin
      r_lvl <= w_lvl_next;
    end
  end

  // Warm-up counter; ready is set on the last warm-up edge and holds until reset.
  always_ff @(posedge fast_clk or posedge rst) begin
    if (rst) begin
      r_warm_cnt <= '0;
      r_ready    <= 1'b0;
    end else if (!r_ready) begin
      r_warm_cnt <= r_warm_cnt + WARM_W'(1);
      r_ready    <= (r_warm_cnt == WARM_W'(WARM_CYCLES - 1));
    end else begin
      r_warm_cnt <= r_warm_cnt;
      r_ready    <= 1'b1;
    end
  end

  // Edge qualification by the runtime mode select.
  always_comb begin
    w_edge_sel = '0;
    case (edge_mode)
      2'b00:   w_edge_sel = w_rise_raw;
      2'b01:   w_edge_sel = w_fall_raw;
      2'b10:   w_edge_sel = w_rise_raw | w_fall_raw;
      default: w_edge_sel = '0;
    endcase
  end

  // Registered pulse outputs, suppressed until warm-up has finished.
  always_ff @(posedge fast_clk or posedge rst) begin
    if (rst) begin
      r_rise <= '0;
      r_fall <= '0;
      r_edge <= '0;
      r_any  <= 1'b0;
    end else begin
      r_rise <= w_rise_raw & w_en_mask;
      r_fall <= w_fall_raw & w_en_mask;
      r_edge <= w_edge_sel & w_en_mask;
      r_any  <= |(w_edge_sel & w_en_mask);
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_cnt
    logic [CNT_WIDTH-1:0] r_cnt;

    // Saturating per-channel counter; clear has priority over an increment.
    always_ff @(posedge fast_clk or posedge rst) begin
      if (rst) begin
        r_cnt <= '0;
      end else if (count_clr) begin
        r_cnt <= '0;
      end else if (w_edge_sel[g] && r_ready && (r_cnt != {CNT_WIDTH{1'b1}})) begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end else begin
        r_cnt <= r_cnt;
      end
    end

    assign edge_count[g*CNT_WIDTH +: CNT_WIDTH] = r_cnt;
  end

  assign ready     = r_ready;
  assign data_rise = r_rise;
  assign data_fall = r_fall;
  assign data_edge = r_edge;
  assign any_edge  = r_any;

endmodule

// File: tb/tb_cdc_multi_edge_detector.sv
// Scoreboard bench for cdc_multi_edge_detector (CHANNELS=4, SYNC_STAGES=2, CNT_WIDTH=3).
module tb_cdc_multi_edge_detector;
  localparam int SS = 2;
`ifdef CDC_GLITCH_FILTER_EN
  localparam int LAT  = SS + 1;
  localparam int WARM = SS + 2;
`else
  localparam int LAT  = SS;
  localparam int WARM = SS + 1;
`endif

  logic        fast_clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  slow_data = 4'b0000;
  logic [1:0]  edge_mode = 2'b00;
  logic        count_clr = 1'b0;
  logic        ready;
  logic [3:0]  data_rise, data_fall, data_edge;
  logic        any_edge;
  logic [11:0] edge_count;

  typedef struct {
    int         cyc;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] edg;
    logic       any;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   d;

  cdc_multi_edge_detector #(.CHANNELS(4), .SYNC_STAGES(SS), .CNT_WIDTH(3)) dut (
    .fast_clk  (fast_clk),
    .rst       (rst),
    .slow_data (slow_data),
    .edge_mode (edge_mode),
    .count_clr (count_clr),
    .ready     (ready),
    .data_rise (data_rise),
    .data_fall (data_fall),
    .data_edge (data_edge),
    .any_edge  (any_edge),
    .edge_count(edge_count)
  );

  always #10 fast_clk = ~fast_clk;

  always @(posedge fast_clk) cyc <= cyc + 1;

  // Monitor: every cycle with pulse activity must match the next expected record.
  always @(negedge fast_clk) begin
    if (!rst && ((data_rise | data_fall | data_edge) != 4'b0000 || any_edge)) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pulse cyc=%0d got rise=%b fall=%b edge=%b any=%b, required none",
                 cyc, data_rise, data_fall, data_edge, any_edge);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.cyc != cyc || e.rise != data_rise || e.fall != data_fall ||
            e.edg != data_edge || e.any != any_edge) begin
          miscompares++;
          $display("FAIL pulse got cyc=%0d rise=%b fall=%b edge=%b any=%b, required cyc=%0d rise=%b fall=%b edge=%b any=%b",
                   cyc, data_rise, data_fall, data_edge, any_edge, e.cyc, e.rise, e.fall, e.edg, e.any);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %h required %h", name, got, exp);
    end
  endtask

  task automatic push(input int at, input logic [3:0] r, input logic [3:0] f,
                      input logic [3:0] e, input logic a);
    exp_t x;
    x.cyc = at; x.rise = r; x.fall = f; x.edg = e; x.any = a;
    q.push_back(x);
  endtask

  // Drive a new level on a falling edge; the following rising edge is the capture edge.
  task automatic drive(input logic [3:0] v);
    @(negedge fast_clk);
    slow_data = v;
    d = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge fast_clk);
  endtask

  task automatic release_and_check_ready(input string name);
    int c;
    @(negedge fast_clk);
    rst = 1'b0;
    c = cyc;
    for (int i = 0; i < 20 && !ready; i++) @(negedge fast_clk);
    chk(name, cyc - c, WARM);
  endtask

  initial begin
    #200us;
    $display("FAIL timeout bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    idle(3);
    chk("reset_state", {ready, data_rise, data_fall, data_edge, any_edge, edge_count}, 32'd0);
    release_and_check_ready("ready_latency");
    idle(2);

    // Single rise on ch0, mode rise.
    drive(4'b0001); push(d + 1 + LAT, 4'b0001, 4'b0000, 4'b0001, 1'b1);
    idle(6);
    chk("count_ch0", edge_count, {3'd0, 3'd0, 3'd0, 3'd1});

    // Mode both: ch1 rise, fall, rise.
    @(negedge fast_clk); edge_mode = 2'b10;
    drive(4'b0011); push(d + 1 + LAT, 4'b0010, 4'b0000, 4'b0010, 1'b1); idle(4);
    drive(4'b0001); push(d + 1 + LAT, 4'b0000, 4'b0010, 4'b0010, 1'b1); idle(4);
    drive(4'b0011); push(d + 1 + LAT, 4'b0010, 4'b0000, 4'b0010, 1'b1); idle(6);
    chk("count_ch1_both", edge_count, {3'd0, 3'd0, 3'd3, 3'd1});

    // Mode rise: ten rises on ch3 saturate a 3-bit counter at 7.
    @(negedge fast_clk); edge_mode = 2'b00;
    for (int k = 0; k < 10; k++) begin
      drive(4'b1011); push(d + 1 + LAT, 4'b1000, 4'b0000, 4'b1000, 1'b1); idle(3);
      drive(4'b0011); push(d + 1 + LAT, 4'b0000, 4'b1000, 4'b0000, 1'b0); idle(3);
      if (k == 6) chk("count_ch3_at7", edge_count, {3'd7, 3'd0, 3'd3, 3'd1});
    end
    idle(3);
    chk("count_ch3_sat", edge_count, {3'd7, 3'd0, 3'd3, 3'd1});

    // count_clr coincident with a qualifying edge.
    drive(4'b1011); push(d + 1 + LAT, 4'b1000, 4'b0000, 4'b1000, 1'b1);
    while (cyc < d + LAT) @(negedge fast_clk);
    count_clr = 1'b1;
    @(negedge fast_clk); count_clr = 1'b0;
    idle(4);
    chk("clr_priority", edge_count, 12'd0);
    drive(4'b0011); push(d + 1 + LAT, 4'b0000, 4'b1000, 4'b0000, 1'b0); idle(6);
    chk("fall_not_counted", edge_count, 12'd0);

    // Inputs high across reset release: no spurious rise.
    @(negedge fast_clk); rst = 1'b1;
    #1 chk("rst_clears", {ready, data_rise, data_fall, data_edge, any_edge, edge_count}, 32'd0);
    slow_data = 4'b1111;
    idle(4);
    release_and_check_ready("ready_latency_high");
    idle(6);
    chk("counts_after_high_release", edge_count, 12'd0);

    // All channels together.
    drive(4'b0000); push(d + 1 + LAT, 4'b0000, 4'b1111, 4'b0000, 1'b0); idle(5);
    drive(4'b1111); push(d + 1 + LAT, 4'b1111, 4'b0000, 4'b1111, 1'b1); idle(5);
    chk("counts_all_one", edge_count, {3'd1, 3'd1, 3'd1, 3'd1});

    // Reset asserted while a pulse is on the outputs.
    @(negedge fast_clk); edge_mode = 2'b10;
    drive(4'b0000);
    do begin @(posedge fast_clk); #3; end while (cyc < d + 1 + LAT);
    chk("pulse_before_rst", {data_fall, data_edge, any_edge}, {4'b1111, 4'b1111, 1'b1});
    rst = 1'b1;
    #1 chk("rst_mid_pulse", {ready, data_rise, data_fall, data_edge, any_edge, edge_count}, 32'd0);
    idle(3);
    edge_mode = 2'b00;
    release_and_check_ready("ready_latency_restart");
    idle(2);

    // One-cycle synchronised glitch on ch2.
    @(negedge fast_clk); slow_data = 4'b0100; d = cyc;
    @(negedge fast_clk); slow_data = 4'b0000;
`ifndef CDC_GLITCH_FILTER_EN
    push(d + 1 + LAT, 4'b0100, 4'b0000, 4'b0100, 1'b1);
    push(d + 2 + LAT, 4'b0000, 4'b0100, 4'b0000, 1'b0);
`endif
    idle(8);
`ifdef CDC_GLITCH_FILTER_EN
    chk("glitch_count", edge_count, 12'd0);
`else
    chk("glitch_count", edge_count, {3'd0, 3'd1, 3'd0, 3'd0});
`endif

    idle(4);
    chk("scoreboard_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
